// File: rtl/reorder_buffer_if.sv
// Dispatch / write-back / commit / operand-read bundle for reorder_buffer.
// The master side is dispatch plus execute plus commit; the slave side is the buffer.
interface reorder_buffer_if #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
);
  logic                  allocValid_i;
  logic [3:0]            allocCommandType_i;
  logic [4:0]            allocRD_i;
  logic                  allocReady_o;
  logic [ROBsizeLog-1:0] allocTag_o;
  logic                  wbValid_i;
  logic [ROBsizeLog-1:0] wbTag_i;
  logic [63:0]           wbData_i;
  logic                  wbFlagValid_i;
  logic [3:0]            wbFlags_i;
  logic                  ROBupdateHead_i;
  logic [ROBsizeLog-1:0] ROBhead_o;
  logic [78:0]           ROBcommitReadData_o;
  logic                  flush_i;
  logic [ROBsizeLog-1:0] readTagA_i;
  logic [ROBsizeLog-1:0] readTagB_i;
  logic [63:0]           readDataA_o;
  logic [63:0]           readDataB_o;
  logic                  readValidA_o;
  logic                  readValidB_o;
  logic [ROBsizeLog-1:0] count_o;

  modport master (
    output allocValid_i, allocCommandType_i, allocRD_i, wbValid_i, wbTag_i, wbData_i,
           wbFlagValid_i, wbFlags_i, ROBupdateHead_i, flush_i, readTagA_i, readTagB_i,
    input  allocReady_o, allocTag_o, ROBhead_o, ROBcommitReadData_o, readDataA_o,
           readDataB_o, readValidA_o, readValidB_o, count_o
  );

  modport slave (
    input  allocValid_i, allocCommandType_i, allocRD_i, wbValid_i, wbTag_i, wbData_i,
           wbFlagValid_i, wbFlags_i, ROBupdateHead_i, flush_i, readTagA_i, readTagB_i,
    output allocReady_o, allocTag_o, ROBhead_o, ROBcommitReadData_o, readDataA_o,
           readDataB_o, readValidA_o, readValidB_o, count_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/commit, out-of-order write-back, full flush.
// Define ROB_WB_BYPASS_EN to forward same-cycle write-back onto the operand read ports.
module reorder_buffer #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int addrSize   = $clog2(ROBsize)
) (
  input logic             clk_i,
  input logic             reset_i,
  reorder_buffer_if.slave rob
);

  // Record: [78:75] type, [74:70] RD, [69] flagValid, [68:65] flags, [64] dataValid, [63:0] data
  logic [78:0]           entry [ROBsize];
  logic [ROBsize-1:0]    valid;
  logic [addrSize-1:0]   head, tail, wbIdx, rdIdx;
  logic [ROBsizeLog-1:0] count;
  logic                  allocOk, wbOk, commitOk;
  logic [ROBsizeLog-1:0] rdTag   [2];
  logic                  rdValid [2];
  logic [63:0]           rdData  [2];

  function automatic logic [addrSize-1:0] incPtr(input logic [addrSize-1:0] p);
    return (p == addrSize'(ROBsize - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wbIdx = rob.wbTag_i[addrSize-1:0];

  always_comb begin
    allocOk  = rob.allocValid_i && (count != ROBsizeLog'(ROBsize));
    wbOk     = rob.wbValid_i && (rob.wbTag_i < ROBsizeLog'(ROBsize)) &&
               valid[wbIdx] && !entry[wbIdx][64];
    commitOk = rob.ROBupdateHead_i && (count != '0) && valid[head] && entry[head][64];
  end

  assign rob.allocReady_o        = (count != ROBsizeLog'(ROBsize));
  assign rob.allocTag_o          = ROBsizeLog'(tail);
  assign rob.ROBhead_o           = ROBsizeLog'(head);
  assign rob.ROBcommitReadData_o = valid[head] ? entry[head] : '0;
  assign rob.count_o             = count;

  assign rdTag[0] = rob.readTagA_i;
  assign rdTag[1] = rob.readTagB_i;

  always_comb begin
    rdIdx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rdValid[p] = 1'b0;
      rdData[p]  = '0;
      rdIdx      = rdTag[p][addrSize-1:0];
      if (rdTag[p] < ROBsizeLog'(ROBsize)) begin
        rdValid[p] = valid[rdIdx] & entry[rdIdx][64];
        rdData[p]  = entry[rdIdx][63:0];
`ifdef ROB_WB_BYPASS_EN
        if (wbOk && (rob.wbTag_i == rdTag[p])) begin
          rdValid[p] = 1'b1;
          rdData[p]  = rob.wbData_i;
        end
`endif
      end
    end
  end

  assign rob.readValidA_o = rdValid[0];
  assign rob.readDataA_o  = rdData[0];
  assign rob.readValidB_o = rdValid[1];
  assign rob.readDataB_o  = rdData[1];

  // Alloc, write-back and commit never target the same slot: alloc needs an
  // empty slot, write-back an incomplete one, commit a complete one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < ROBsize; i++) entry[i] <= '0;
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rob.flush_i) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (allocOk) begin
        entry[tail] <= {rob.allocCommandType_i, rob.allocRD_i, 70'b0};
        valid[tail] <= 1'b1;
        tail        <= incPtr(tail);
      end
      if (wbOk) begin
        entry[wbIdx][69:0] <= {rob.wbFlagValid_i, rob.wbFlags_i, 1'b1, rob.wbData_i};
      end
      if (commitOk) begin
        entry[head] <= '0;
        valid[head] <= 1'b0;
        head        <= incPtr(head);
      end
      count <= count + ROBsizeLog'(allocOk) - ROBsizeLog'(commitOk);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a behavioural model.
// Build with ROB_WB_BYPASS_EN defined to check the forwarding variant.
module tb_reorder_buffer;
  localparam int N  = 8;
  localparam int TW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROBsize(N)) bus ();
  reorder_buffer #(.ROBsize(N)) dut (.clk_i(clk), .reset_i(rst), .rob(bus));

  // Model: per-tag records plus tail and occupancy; head is derived from them.
  bit          mValid [N];
  bit          mDone  [N];
  bit          mFv    [N];
  logic [3:0]  mType  [N];
  logic [3:0]  mFlags [N];
  logic [4:0]  mRd    [N];
  logic [63:0] mData  [N];
  int          mTail, mCount;
  int          vectors, miscompares;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mHead();
    return (mTail + N - mCount) % N;
  endfunction

  function automatic bit wbWouldAccept();
    return bus.wbValid_i && (int'(bus.wbTag_i) < N) &&
           mValid[bus.wbTag_i] && !mDone[bus.wbTag_i];
  endfunction

  task automatic clearEntry(input int i);
    mValid[i] = 0; mDone[i] = 0; mFv[i] = 0;
    mType[i] = '0; mFlags[i] = '0; mRd[i] = '0; mData[i] = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) clearEntry(i);
    mTail = 0; mCount = 0;
  endtask

  task automatic modelStep();
    int h, t;
    bit alloc, wb, com;
    if (rst) begin
      modelReset();
    end else if (bus.flush_i) begin
      for (int i = 0; i < N; i++) begin mValid[i] = 0; mDone[i] = 0; end
      mTail = 0; mCount = 0;
    end else begin
      h     = mHead();
      t     = int'(bus.wbTag_i);
      alloc = bus.allocValid_i && (mCount < N);
      wb    = wbWouldAccept();
      com   = bus.ROBupdateHead_i && (mCount > 0) && mDone[h];
      if (wb) begin
        mDone[t] = 1; mData[t] = bus.wbData_i;
        mFv[t] = bus.wbFlagValid_i; mFlags[t] = bus.wbFlags_i;
      end
      if (com) clearEntry(h);
      if (alloc) begin
        clearEntry(mTail);
        mValid[mTail] = 1; mType[mTail] = bus.allocCommandType_i; mRd[mTail] = bus.allocRD_i;
        mTail = (mTail + 1) % N;
      end
      mCount = mCount + int'(alloc) - int'(com);
    end
  endtask

  task automatic checkRead(input string port, input int tag, input logic v, input logic [63:0] d);
    bit ev, checkData;
    logic [63:0] ed;
    ev = 0; ed = '0; checkData = 1;
    if (tag < N) begin
      ev = mValid[tag] && mDone[tag];
      ed = mData[tag];
      checkData = mValid[tag];
    end
`ifdef ROB_WB_BYPASS_EN
    if (wbWouldAccept() && (int'(bus.wbTag_i) == tag)) begin
      ev = 1; ed = bus.wbData_i; checkData = 1;
    end
`endif
    checkVal({"readValid", port}, v, ev);
    if (checkData) checkVal({"readData", port}, d, ed);
  endtask

  task automatic checkAll();
    int h;
    logic [78:0] expRec;
    h = mHead();
    expRec = mValid[h] ? {mType[h], mRd[h], mFv[h], mFlags[h], mDone[h], mData[h]} : '0;
    checkVal("allocReady", bus.allocReady_o, mCount != N);
    checkVal("allocTag", bus.allocTag_o, mTail);
    checkVal("head", bus.ROBhead_o, h);
    checkVal("commitData", bus.ROBcommitReadData_o, expRec);
    checkVal("count", bus.count_o, mCount);
    checkRead("A", int'(bus.readTagA_i), bus.readValidA_o, bus.readDataA_o);
    checkRead("B", int'(bus.readTagB_i), bus.readValidB_o, bus.readDataB_o);
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    bus.allocValid_i = 0; bus.allocCommandType_i = '0; bus.allocRD_i = '0;
    bus.wbValid_i = 0; bus.wbTag_i = '0; bus.wbData_i = '0;
    bus.wbFlagValid_i = 0; bus.wbFlags_i = '0;
    bus.ROBupdateHead_i = 0; bus.flush_i = 0;
    bus.readTagA_i = '0; bus.readTagB_i = '0;
  endtask

  task automatic doFlush();
    idle(); bus.flush_i = 1; cycle(); idle();
  endtask

  task automatic allocN(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); bus.allocValid_i = 1; bus.allocRD_i = 5'(i + 1); cycle();
    end
    idle();
  endtask

  task automatic wb(input int tag, input logic [63:0] data);
    idle(); bus.wbValid_i = 1; bus.wbTag_i = TW'(tag); bus.wbData_i = data; cycle(); idle();
  endtask

  task automatic commitOne();
    idle(); bus.ROBupdateHead_i = 1; cycle(); idle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    idle(); modelReset();
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    checkVal("rstReady", bus.allocReady_o, 1);
    checkVal("rstCommitData", bus.ROBcommitReadData_o, 0);

    // Fill to full; ninth request must be dropped.
    allocN(9);
    checkVal("fullCount", bus.count_o, 8);
    checkVal("fullReady", bus.allocReady_o, 0);

    // Incomplete head blocks commit.
    doFlush(); allocN(3);
    wb(2, 64'h55);
    commitOne();
    checkVal("blockedHead", bus.ROBhead_o, 0);
    checkVal("blockedCount", bus.count_o, 3);
    wb(0, 64'h11);
    checkVal("headDataValid", bus.ROBcommitReadData_o[64], 1);
    checkVal("headData", bus.ROBcommitReadData_o[63:0], 64'h11);
    commitOne();
    checkVal("retireHead", bus.ROBhead_o, 1);
    checkVal("retireCount", bus.count_o, 2);

    // Wrap-around of the tail.
    doFlush(); allocN(8);
    for (int i = 0; i < 3; i++) wb(i, 64'(100 + i));
    repeat (3) commitOne();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.allocValid_i = 1; #1;
      checkVal("wrapTag", bus.allocTag_o, i);
      cycle();
    end
    idle();
    checkVal("wrapCount", bus.count_o, 8);
    checkVal("wrapHead", bus.ROBhead_o, 3);

    // Simultaneous alloc and commit keeps occupancy.
    doFlush(); allocN(5); wb(0, 64'hABC);
    idle(); bus.allocValid_i = 1; bus.ROBupdateHead_i = 1; cycle(); idle();
    checkVal("simulCount", bus.count_o, 5);
    checkVal("simulHead", bus.ROBhead_o, 1);

    // Flush dominates same-cycle alloc and write-back.
    doFlush(); allocN(5);
    idle(); bus.flush_i = 1; bus.allocValid_i = 1;
    bus.wbValid_i = 1; bus.wbTag_i = TW'(3); bus.wbData_i = 64'h77; cycle(); idle();
    checkVal("flushCount", bus.count_o, 0);
    checkVal("flushTag", bus.allocTag_o, 0);
    wb(3, 64'h99);
    bus.readTagA_i = TW'(3); #1;
    checkVal("staleWb", bus.readValidA_o, 0);

    // Same-cycle write-back visibility on the read port.
    doFlush(); allocN(4);
    idle(); bus.wbValid_i = 1; bus.wbTag_i = TW'(3); bus.wbData_i = 64'h1234;
    bus.readTagA_i = TW'(3); #1;
`ifdef ROB_WB_BYPASS_EN
    checkVal("bypassValid", bus.readValidA_o, 1);
    checkVal("bypassData", bus.readDataA_o, 64'h1234);
`else
    checkVal("noBypassValid", bus.readValidA_o, 0);
`endif
    cycle(); idle(); bus.readTagA_i = TW'(3); #1;
    checkVal("wbValidNext", bus.readValidA_o, 1);
    checkVal("wbDataNext", bus.readDataA_o, 64'h1234);

    // Asynchronous reset mid-cycle with live entries.
    doFlush(); allocN(3);
    #3 rst = 1;
    #1;
    checkVal("asyncCount", bus.count_o, 0);
    checkVal("asyncHead", bus.ROBhead_o, 0);
    checkVal("asyncCommitData", bus.ROBcommitReadData_o, 0);
    checkVal("asyncReady", bus.allocReady_o, 1);
    modelReset();
    cycle();
    rst = 0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.allocValid_i       = ($urandom_range(0, 99) < 60);
      bus.allocCommandType_i = 4'($urandom);
      bus.allocRD_i          = 5'($urandom);
      bus.wbValid_i          = ($urandom_range(0, 99) < 60);
      bus.wbTag_i            = TW'($urandom_range(0, N));
      bus.wbData_i           = {$urandom, $urandom};
      bus.wbFlagValid_i      = 1'($urandom);
      bus.wbFlags_i          = 4'($urandom);
      bus.ROBupdateHead_i    = ($urandom_range(0, 99) < 50);
      bus.flush_i            = ($urandom_range(0, 99) < 2);
      bus.readTagA_i         = TW'($urandom_range(0, N));
      bus.readTagB_i         = TW'($urandom_range(0, N));
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
